clk_reset_seq: RTL and testbench



---
 rtl/clk_reset_pkg.sv | 18 +
 rtl/clk_reset_seq_sync_2ff.sv | 21 ++
 rtl/clk_reset_seq.sv | 137 +++++++++++++
 tb/tb_clk_reset_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/clk_reset_pkg.sv
// Shared types for the post-PLL reset/clock-enable sequencer.
// State encodings are visible on seq_state, so they are pinned explicitly.
package clk_reset_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RUN       = 2'd3
   } seq_state_t;

   localparam int DIV_W = 4;

   function automatic logic enables_live(input seq_state_t st);
      return (st == ST_HOLD) || (st == ST_RUN);
   endfunction

endpackage

// File: rtl/clk_reset_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_reset_seq.sv
// Turns raw PLL lock into a clean core reset and phase-aligned 12/6/3/1.5 MHz
// enables derived from the 24 MHz clk_sys.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   ST_WAIT_LOCK | no synchronized lock; reset held, divider parked at 0
//   ST_STABLE    | lock seen; counting STABLE_CYCLES of continuous lock
//   ST_HOLD      | reset still asserted but enables running for HOLD_CYCLES
//   ST_RUN       | core out of reset; enables running
module clk_reset_seq
   import clk_reset_pkg::*;
#(
   parameter int STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES   = 256
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       reset_req,
   output logic       core_reset,
   output logic       ce_12m,
   output logic       ce_6m,
   output logic       ce_3m,
   output logic       ce_1m5,
   output logic       lock_drop,
   output logic [1:0] seq_state
);

   localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic             lock_s;
   logic             live;

   sync_2ff u_lock_sync (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .d       (pll_locked),
      .q       (lock_s)
   );

   // Down-counter: loaded with N-1 on entry, terminal count at zero.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_WAIT_LOCK;
         cnt        <= '0;
         div        <= '0;
         core_reset <= 1'b1;
         lock_drop  <= 1'b0;
      end else begin
         lock_drop <= 1'b0;
         case (state)
            ST_WAIT_LOCK: begin
               div        <= '0;
               core_reset <= 1'b1;
               if (lock_s) begin
                  state <= ST_STABLE;
                  cnt   <= STABLE_LOAD;
               end
            end
            ST_STABLE: begin
               div        <= '0;
               core_reset <= 1'b1;
               if (!lock_s) begin
                  state     <= ST_WAIT_LOCK;
                  cnt       <= '0;
                  lock_drop <= 1'b1;
               end else if (cnt == '0) begin
                  state <= ST_HOLD;
                  cnt   <= HOLD_LOAD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!lock_s) begin
                  state      <= ST_WAIT_LOCK;
                  cnt        <= '0;
                  div        <= '0;
                  core_reset <= 1'b1;
                  lock_drop  <= 1'b1;
               end else begin
                  div <= div + DIV_W'(1);
                  if (reset_req) begin
                     cnt        <= HOLD_LOAD;
                     core_reset <= 1'b1;
                  end else if (cnt == '0) begin
                     state      <= ST_RUN;
                     core_reset <= 1'b0;
                  end else begin
                     cnt        <= cnt - CNT_W'(1);
                     core_reset <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state      <= ST_WAIT_LOCK;
                  cnt        <= '0;
                  div        <= '0;
                  core_reset <= 1'b1;
                  lock_drop  <= 1'b1;
               end else begin
                  // Divider keeps phase across a RUN->HOLD re-reset.
                  div <= div + DIV_W'(1);
                  if (reset_req) begin
                     state      <= ST_HOLD;
                     cnt        <= HOLD_LOAD;
                     core_reset <= 1'b1;
                  end else begin
                     core_reset <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= ST_WAIT_LOCK;
               cnt        <= '0;
               div        <= '0;
               core_reset <= 1'b1;
            end
         endcase
      end
   end

   assign live      = enables_live(state);
   assign ce_12m    = live & div[0];
   assign ce_6m     = live & (div[1:0] == 2'b11);
   assign ce_3m     = live & (div[2:0] == 3'b111);
   assign ce_1m5    = live & (div == 4'b1111);
   assign seq_state = state;

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq with STABLE_CYCLES=4, HOLD_CYCLES=3:
// table-driven bring-up, then hand-written multi-cycle corner sequences.
module tb_clk_reset_seq;

   logic       clk_sys = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       reset_req;
   logic       core_reset;
   logic       ce_12m, ce_6m, ce_3m, ce_1m5;
   logic       lock_drop;
   logic [1:0] seq_state;

   int errors = 0;
   int checks = 0;

   int         mdiv;
   logic [1:0] mprev;

   always #5 clk_sys = ~clk_sys;

   clk_reset_seq #(.STABLE_CYCLES(4), .HOLD_CYCLES(3)) dut (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .reset_req  (reset_req),
      .core_reset (core_reset),
      .ce_12m     (ce_12m),
      .ce_6m      (ce_6m),
      .ce_3m      (ce_3m),
      .ce_1m5     (ce_1m5),
      .lock_drop  (lock_drop),
      .seq_state  (seq_state)
   );

   typedef struct {
      logic       lock;
      logic       req;
      logic [1:0] st;
      logic       cr;
      logic [3:0] ce;   // {ce_1m5, ce_3m, ce_6m, ce_12m}
      logic       ld;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [7:0] outs();
      return {seq_state, core_reset, ce_1m5, ce_3m, ce_6m, ce_12m, lock_drop};
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got state=%0d rst=%b ce=%b ld=%b, want state=%0d rst=%b ce=%b ld=%b",
                  name, got[7:6], got[5], got[4:1], got[0], exp[7:6], exp[5], exp[4:1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   function automatic logic [3:0] ce_model(input logic [1:0] st, input int d);
      logic [3:0] dv;
      dv = 4'(d);
      if (st < 2'd2) return 4'b0000;
      return {dv == 4'hf, dv[2:0] == 3'h7, dv[1:0] == 2'h3, dv[0]};
   endfunction

   // Advance one edge; enables predicted from an independent divider model.
   task automatic cyc(input logic [1:0] st, input logic cr, input logic ld, input string name);
      @(posedge clk_sys);
      #1;
      if (st >= 2'd2) mdiv = (mprev >= 2'd2) ? (mdiv + 1) % 16 : 0;
      else            mdiv = 0;
      mprev = st;
      check(name, outs(), {st, cr, ce_model(st, mdiv), ld});
   endtask

   initial begin
      int n12, n6, n3, n15;

      // e0..e13 after reset release with lock already high
      vecs[0]  = '{1, 0, 2'd0, 1, 4'b0000, 0};
      vecs[1]  = '{1, 0, 2'd0, 1, 4'b0000, 0};
      vecs[2]  = '{1, 0, 2'd1, 1, 4'b0000, 0};
      vecs[3]  = '{1, 0, 2'd1, 1, 4'b0000, 0};
      vecs[4]  = '{1, 0, 2'd1, 1, 4'b0000, 0};
      vecs[5]  = '{1, 0, 2'd1, 1, 4'b0000, 0};
      vecs[6]  = '{1, 0, 2'd2, 1, 4'b0000, 0};
      vecs[7]  = '{1, 0, 2'd2, 1, 4'b0001, 0};
      vecs[8]  = '{1, 0, 2'd2, 1, 4'b0000, 0};
      vecs[9]  = '{1, 0, 2'd3, 0, 4'b0011, 0};
      vecs[10] = '{1, 0, 2'd3, 0, 4'b0000, 0};
      vecs[11] = '{1, 0, 2'd3, 0, 4'b0001, 0};
      vecs[12] = '{1, 0, 2'd3, 0, 4'b0000, 0};
      vecs[13] = '{1, 0, 2'd3, 0, 4'b0111, 0};

      rst_n      = 1'b0;
      pll_locked = 1'b0;
      reset_req  = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      check("reset_state", outs(), {2'd0, 1'b1, 4'b0000, 1'b0});

      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         pll_locked = vecs[i].lock;
         reset_req  = vecs[i].req;
         @(posedge clk_sys);
         #1;
         check($sformatf("bringup_e%0d", i), outs(),
               {vecs[i].st, vecs[i].cr, vecs[i].ce, vecs[i].ld});
      end
      mprev = 2'd3;
      mdiv  = 7;

      // 32 cycles of RUN: pattern and pulse rates
      n12 = 0; n6 = 0; n3 = 0; n15 = 0;
      for (int i = 0; i < 32; i++) begin
         cyc(2'd3, 1'b0, 1'b0, $sformatf("run_c%0d", i));
         n12 += int'(ce_12m);
         n6  += int'(ce_6m);
         n3  += int'(ce_3m);
         n15 += int'(ce_1m5);
         if (ce_1m5) check_int("ce_aligned", int'({ce_12m, ce_6m, ce_3m}), 7);
      end
      check_int("ce_12m_count", n12, 16);
      check_int("ce_6m_count",  n6,  8);
      check_int("ce_3m_count",  n3,  4);
      check_int("ce_1m5_count", n15, 2);

      // reset_req held 5 edges in RUN, then released
      reset_req = 1'b1;
      for (int i = 0; i < 5; i++) cyc(2'd2, 1'b1, 1'b0, $sformatf("req_hold%0d", i));
      reset_req = 1'b0;
      cyc(2'd2, 1'b1, 1'b0, "req_rel0");
      cyc(2'd2, 1'b1, 1'b0, "req_rel1");
      cyc(2'd3, 1'b0, 1'b0, "req_rel_run");

      // lock loss and reset_req reach the state register together
      pll_locked = 1'b0;
      cyc(2'd3, 1'b0, 1'b0, "loss_sync0");
      cyc(2'd3, 1'b0, 1'b0, "loss_sync1");
      reset_req = 1'b1;
      cyc(2'd0, 1'b1, 1'b1, "loss_wins");
      reset_req = 1'b0;
      cyc(2'd0, 1'b1, 1'b0, "loss_after");

      // re-lock, then a one-cycle lock glitch seen at STABLE counter=2
      pll_locked = 1'b1;
      cyc(2'd0, 1'b1, 1'b0, "relock_g0");
      cyc(2'd0, 1'b1, 1'b0, "relock_g1");
      cyc(2'd1, 1'b1, 1'b0, "relock_g2");
      pll_locked = 1'b0;
      cyc(2'd1, 1'b1, 1'b0, "glitch_g3");
      pll_locked = 1'b1;
      cyc(2'd1, 1'b1, 1'b0, "glitch_g4");
      cyc(2'd0, 1'b1, 1'b1, "glitch_drop");
      for (int i = 0; i < 4; i++) cyc(2'd1, 1'b1, 1'b0, $sformatf("restable%0d", i));
      for (int i = 0; i < 3; i++) cyc(2'd2, 1'b1, 1'b0, $sformatf("rehold%0d", i));
      cyc(2'd3, 1'b0, 1'b0, "rerun");
      cyc(2'd3, 1'b0, 1'b0, "rerun1");

      // asynchronous reset mid-RUN, between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", outs(), {2'd0, 1'b1, 4'b0000, 1'b0});
      @(posedge clk_sys);
      #1;
      check("reset_held", outs(), {2'd0, 1'b1, 4'b0000, 1'b0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
